// File: rtl/serial_instr_sequencer.sv
// Serial instruction sequencer: turns the 1-bit serial line into N-bit words,
// queues them in a DEPTH-entry FIFO and hands them to the core via valid/ready.
// Optional even-parity bit per frame when SERIAL_PARITY_EN is defined.
// Ports:
//   clk, rst        clock, async active-low reset
//   data            serial line (idles high)
//   clr_err         synchronous clear of sticky err flags
//   instr_ready     core consumes the head word this cycle
//   instr_data      FIFO head word (zero while empty)
//   instr_valid     FIFO non-empty
//   write           one-cycle pulse after a word is pushed
//   busy            frame reception in progress
//   count           FIFO occupancy 0..DEPTH
//   err             sticky flags: [0] frame/parity, [1] overflow
module serial_instr_sequencer #(
  parameter int unsigned N     = 2,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       data,
  input  logic                       clr_err,
  input  logic                       instr_ready,
  output logic [N-1:0]               instr_data,
  output logic                       instr_valid,
  output logic                       write,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     count,
  output logic [1:0]                 err
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned CNTW = PW + 1;
  localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    STOP   = 2'd2,
    PARITY = 2'd3
  } state_t;

  state_t          state, next_state;
  logic [CW-1:0]   bit_cnt;
  logic [N-1:0]    sreg;
  logic [N-1:0]    mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            par_bad;
  logic            full;
  logic            pop;
  logic            push_c, ferr_c, oerr_c, shift_c, last_c;

  assign full        = (count == CNTW'(DEPTH));
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready;
  assign busy        = (state != IDLE);
  assign instr_data  = instr_valid ? mem[rd_ptr] : '0;
  assign last_c      = (bit_cnt == CW'(N - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state and frame-decision strobes
  always_comb begin
    next_state = state;
    push_c     = 1'b0;
    ferr_c     = 1'b0;
    oerr_c     = 1'b0;
    shift_c    = 1'b0;
    case (state)
      IDLE: if (!data) next_state = SHIFT;
      SHIFT: begin
        shift_c = 1'b1;
`ifdef SERIAL_PARITY_EN
        if (last_c) next_state = PARITY;
`else
        if (last_c) next_state = STOP;
`endif
      end
`ifdef SERIAL_PARITY_EN
      PARITY: next_state = STOP;
`else
      PARITY: next_state = IDLE;
`endif
      STOP: begin
        next_state = IDLE;
        // Full check uses pre-edge count, so a same-edge pop cannot make room
        if (!data || par_bad) ferr_c = 1'b1;
        else if (full)        oerr_c = 1'b1;
        else                  push_c = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

  // Bit counter and shift register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
      sreg    <= '0;
    end else if (state == IDLE) begin
      bit_cnt <= '0;
    end else if (shift_c) begin
      sreg[bit_cnt] <= data;
      bit_cnt       <= bit_cnt + CW'(1);
    end
  end

`ifdef SERIAL_PARITY_EN
  // Even parity over data bits plus parity bit must be zero
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 par_bad <= 1'b0;
    else if (state == PARITY) par_bad <= (^sreg) ^ data;
  end
`else
  assign par_bad = 1'b0;
`endif

  // FIFO storage; contents are don't-care while count says empty
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= sreg;
  end

  // FIFO pointers, occupancy, write pulse and sticky errors
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      write  <= 1'b0;
      err    <= 2'b00;
    end else begin
      write <= push_c;
      if (push_c) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
      case ({push_c, pop})
        2'b10:   count <= count + CNTW'(1);
        2'b01:   count <= count - CNTW'(1);
        default: count <= count;
      endcase
      // New errors override a same-edge clear
      err <= (clr_err ? 2'b00 : err) | {oerr_c, ferr_c};
    end
  end

endmodule

// File: tb/tb_serial_instr_sequencer.sv
module tb_serial_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       data;
  logic       clr_err;
  logic       instr_ready;
  logic [1:0] instr_data;
  logic       instr_valid;
  logic       write;
  logic       busy;
  logic [2:0] count;
  logic [1:0] err;

  int checks   = 0;
  int failures = 0;

  serial_instr_sequencer #(.N(2), .DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .data        (data),
    .clr_err     (clr_err),
    .instr_ready (instr_ready),
    .instr_data  (instr_data),
    .instr_valid (instr_valid),
    .write       (write),
    .busy        (busy),
    .count       (count),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one serial bit and let one rising edge sample it
  task automatic bit_in(input logic b);
    data = b;
    @(posedge clk);
    #1;
  endtask

  // Start bit, data bits LSB first, and parity bit when enabled
  task automatic send_body(input logic [1:0] w);
    bit_in(1'b0);
    bit_in(w[0]);
    bit_in(w[1]);
`ifdef SERIAL_PARITY_EN
    bit_in(^w);
`endif
  endtask

  task automatic send_frame(input logic [1:0] w, input logic stop);
    send_body(w);
    bit_in(stop);
    data = 1'b1;
  endtask

  initial begin
    rst = 1'b0; data = 1'b1; clr_err = 1'b0; instr_ready = 1'b0;

    // Reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_write", 32'(write), 32'd0);
    check("rst_err",   32'(err), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_data",  32'(instr_data), 32'd0);
    rst = 1'b1;
    bit_in(1'b1);

    // Single frame, word 01
    bit_in(1'b0);
    check("busy_after_start", 32'(busy), 32'd1);
    bit_in(1'b1);
    bit_in(1'b0);
`ifdef SERIAL_PARITY_EN
    bit_in(1'b1);
    check("write_not_before_stop", 32'(write), 32'd0);
`else
    check("write_not_before_stop", 32'(write), 32'd0);
`endif
    bit_in(1'b1);
    check("single_write", 32'(write), 32'd1);
    check("single_count", 32'(count), 32'd1);
    check("single_valid", 32'(instr_valid), 32'd1);
    check("single_data",  32'(instr_data), 32'h1);
    check("single_busy",  32'(busy), 32'd0);
    bit_in(1'b1);
    check("single_write_one_cycle", 32'(write), 32'd0);
    check("single_count_hold", 32'(count), 32'd1);
    instr_ready = 1'b1;
    bit_in(1'b1);
    instr_ready = 1'b0;
    check("pop_count", 32'(count), 32'd0);
    check("pop_valid", 32'(instr_valid), 32'd0);
    instr_ready = 1'b1;
    bit_in(1'b1);
    instr_ready = 1'b0;
    check("pop_empty_ignored", 32'(count), 32'd0);

    // Framing error
    send_frame(2'b11, 1'b0);
    check("ferr_write", 32'(write), 32'd0);
    check("ferr_count", 32'(count), 32'd0);
    check("ferr_err",   32'(err), 32'h1);
    bit_in(1'b1);
    check("ferr_sticky", 32'(err), 32'h1);
    clr_err = 1'b1;
    bit_in(1'b1);
    clr_err = 1'b0;
    check("ferr_cleared", 32'(err), 32'h0);

    // Overflow: five frames, fifth dropped
    send_frame(2'b00, 1'b1); bit_in(1'b1);
    send_frame(2'b01, 1'b1); bit_in(1'b1);
    send_frame(2'b10, 1'b1); bit_in(1'b1);
    send_frame(2'b11, 1'b1);
    check("fill_count", 32'(count), 32'd4);
    check("fill_err",   32'(err), 32'h0);
    bit_in(1'b1);
    send_frame(2'b01, 1'b1);
    check("ovf_write", 32'(write), 32'd0);
    check("ovf_count", 32'(count), 32'd4);
    check("ovf_err",   32'(err), 32'h2);
    instr_ready = 1'b1;
    check("drain_w0", 32'(instr_data), 32'h0);
    bit_in(1'b1);
    check("drain_w1", 32'(instr_data), 32'h1);
    bit_in(1'b1);
    check("drain_w2", 32'(instr_data), 32'h2);
    bit_in(1'b1);
    check("drain_w3", 32'(instr_data), 32'h3);
    bit_in(1'b1);
    instr_ready = 1'b0;
    check("drain_count", 32'(count), 32'd0);
    check("drain_valid", 32'(instr_valid), 32'd0);
    // Same-edge clear and new error: new error wins
    send_body(2'b10);
    clr_err = 1'b1;
    bit_in(1'b0);
    clr_err = 1'b0;
    data = 1'b1;
    check("clr_vs_new_err", 32'(err), 32'h1);
    clr_err = 1'b1;
    bit_in(1'b1);
    clr_err = 1'b0;

    // Full FIFO with same-edge pop: push still rejected
    send_frame(2'b00, 1'b1); bit_in(1'b1);
    send_frame(2'b01, 1'b1); bit_in(1'b1);
    send_frame(2'b10, 1'b1); bit_in(1'b1);
    send_frame(2'b11, 1'b1); bit_in(1'b1);
    send_body(2'b10);
    instr_ready = 1'b1;
    bit_in(1'b1);
    instr_ready = 1'b0;
    check("fullpop_count", 32'(count), 32'd3);
    check("fullpop_err",   32'(err), 32'h2);
    check("fullpop_write", 32'(write), 32'd0);
    check("fullpop_head",  32'(instr_data), 32'h1);
    // Not full with same-edge pop: both happen
    send_body(2'b01);
    instr_ready = 1'b1;
    bit_in(1'b1);
    instr_ready = 1'b0;
    check("pushpop_count", 32'(count), 32'd3);
    check("pushpop_write", 32'(write), 32'd1);
    check("pushpop_head",  32'(instr_data), 32'h2);

    // Reset mid-frame with FIFO occupied
    bit_in(1'b0);
    bit_in(1'b1);
    check("mid_busy_before", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_busy_reset",  32'(busy), 32'd0);
    check("mid_count_reset", 32'(count), 32'd0);
    check("mid_err_reset",   32'(err), 32'h0);
    bit_in(1'b0);
    bit_in(1'b1);
    rst = 1'b1;
    bit_in(1'b1);
    bit_in(1'b1);
    bit_in(1'b1);
    check("mid_write_after", 32'(write), 32'd0);
    check("mid_count_after", 32'(count), 32'd0);
    check("mid_busy_after",  32'(busy), 32'd0);

`ifdef SERIAL_PARITY_EN
    // Parity mismatch, then correct parity
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
    check("par_bad_err",   32'(err), 32'h1);
    check("par_bad_write", 32'(write), 32'd0);
    check("par_bad_count", 32'(count), 32'd0);
    clr_err = 1'b1;
    bit_in(1'b1);
    clr_err = 1'b0;
    bit_in(1'b0); bit_in(1'b1); bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
    check("par_ok_write", 32'(write), 32'd1);
    check("par_ok_count", 32'(count), 32'd1);
    check("par_ok_data",  32'(instr_data), 32'h3);
    check("par_ok_err",   32'(err), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
